// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: lock inputs, PLL reset and domain reset outputs.
// The supervisor takes the master side; the PLL/reset fabric the slave side.
interface pll_lock_supervisor_if #(
  parameter int NUM_DOMAINS = 3
);
  logic                   pll_locked;
  logic                   force_relock;
  logic                   fault_clear;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   all_ready;
  logic                   fault;
  logic [7:0]             loss_count;
  logic [7:0]             retry_count;

  modport master (
    input  pll_locked, force_relock, fault_clear,
    output pll_rst, domain_rst_n, all_ready, fault,
    output loss_count, retry_count
  );

  modport slave (
    output pll_locked, force_relock, fault_clear,
    input  pll_rst, domain_rst_n, all_ready, fault,
    input  loss_count, retry_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset, lock qualification, ordered domain release.
// Define PLL_SUP_GLITCH_FILTER_EN to ignore lock dropouts shorter than 4 cycles.
module pll_lock_supervisor #(
  parameter int NUM_DOMAINS         = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_GAP_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_supervisor_if.master bus
);
  localparam int CM0 = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                       PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CMX = (CM0 > RELEASE_GAP_CYCLES) ?
                       CM0 : RELEASE_GAP_CYCLES;
  localparam int CW  = $clog2(CMX + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int IW  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [2:0] {
    PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [7:0]             loss_q, loss_d;
  logic [7:0]             retry_q, retry_d;
  logic                   pll_rst_q, ready_q, fault_q;
  logic                   lock_m, lock_s;
  logic                   in_rr, lost;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= bus.pll_locked;
      lock_s <= lock_m;
    end
  end

  assign in_rr = (state_q == RELEASE) || (state_q == RUN);

`ifdef PLL_SUP_GLITCH_FILTER_EN
  logic [1:0] low_q;

  // Saturates at 3, so a 4th low sample qualifies the loss.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)
      low_q <= 2'd0;
    else if (lock_s || !in_rr)
      low_q <= 2'd0;
    else if (low_q != 2'd3)
      low_q <= low_q + 2'd1;
  end

  assign lost = !lock_s && (low_q == 2'd3);
`else
  assign lost = !lock_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    if (state_q != FAULT && (bus.force_relock || (in_rr && lost))) begin
      state_d = PLL_RESET;
      cnt_d   = '0;
      tmo_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      if (in_rr && lost && loss_q != 8'hff)
        loss_d = loss_q + 8'd1;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (tmo_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            retry_d = retry_q + 8'd1;
            tmo_d   = '0;
            cnt_d   = '0;
            state_d = (retry_d == 8'(MAX_RETRIES)) ? FAULT : PLL_RESET;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        STABLE: begin
          // Timeout timer is left alone so flicker cannot extend it.
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d = RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = NUM_DOMAINS'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RELEASE: begin
          if (idx_q == IW'(NUM_DOMAINS - 1)) begin
            state_d = RUN;
            retry_d = '0;
          end else if (cnt_q == CW'(RELEASE_GAP_CYCLES - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + IW'(1);
            dom_d = dom_q | (NUM_DOMAINS'(1) << idx_d);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: retry_d = '0;
        FAULT: begin
          if (bus.fault_clear) begin
            state_d = PLL_RESET;
            retry_d = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = PLL_RESET;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLL_RESET;
      cnt_q     <= '0;
      tmo_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '0;
      loss_q    <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      loss_q    <= loss_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == PLL_RESET) || (state_d == FAULT);
      ready_q   <= (state_d == RUN);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.domain_rst_n = dom_q;
  assign bus.all_ready    = ready_q;
  assign bus.fault        = fault_q;
  assign bus.loss_count   = loss_q;
  assign bus.retry_count  = retry_q;
endmodule
